// File: rtl/sound_sequencer.sv
// Fixed-priority sound effect sequencer: plays a four-note melody per request id onto one tone generator.
// Latency: request to first note is 2 clk edges from IDLE; all outputs registered. No backpressure: requests merge into pending bits.
// Optional SOUND_PREEMPT_EN: a higher-priority pending id restarts playback immediately.
module sound_sequencer #(
    parameter int NOTE_TICKS = 6,
    parameter int GAP_TICKS  = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enableSound,
    input  logic       tick,
    input  logic [3:0] req,
    output logic       enable_out,
    output logic [3:0] tone,
    output logic       busy,
    output logic [1:0] active_id,
    output logic       done
);

    localparam logic [7:0] NOTE_T = 8'(NOTE_TICKS);
    localparam logic [7:0] GAP_T  = 8'(GAP_TICKS);
    localparam logic [3:0] REST   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] pending, pending_nxt;
    logic [1:0] note_idx, note_idx_nxt;
    logic [7:0] tick_cnt, tick_cnt_nxt;
    logic       enable_nxt;
    logic [3:0] tone_nxt;
    logic       busy_nxt;
    logic [1:0] id_nxt;
    logic       done_nxt;

    logic       top_vld;
    logic [1:0] top_id;
    logic       preempt;
    logic       start;
    logic       next_note;
    logic [1:0] idx_inc;
    logic [3:0] start_note;
    logic [3:0] cont_note;

    function automatic logic [3:0] melody(input logic [1:0] id, input logic [1:0] idx);
        logic [3:0] n;
        case ({id, idx})
            4'h0: n = 4'h0;
            4'h1: n = 4'h2;
            4'h2: n = 4'h4;
            4'h3: n = 4'hF;
            4'h4: n = 4'h7;
            4'h5: n = 4'h9;
            4'h6: n = 4'hB;
            4'h7: n = 4'hC;
            4'h8: n = 4'h7;
            4'h9: n = 4'h5;
            4'hA: n = 4'h3;
            4'hB: n = 4'h0;
            4'hC: n = 4'h0;
            4'hD: n = 4'h4;
            4'hE: n = 4'h7;
            default: n = 4'hC;
        endcase
        return n;
    endfunction

    // Highest set pending bit wins; id3 (win) has top priority.
    always_comb begin
        top_vld = |pending;
        top_id  = 2'd0;
        if (pending[3])      top_id = 2'd3;
        else if (pending[2]) top_id = 2'd2;
        else if (pending[1]) top_id = 2'd1;
    end

`ifdef SOUND_PREEMPT_EN
    assign preempt = (state != IDLE) && top_vld && (top_id > active_id);
`else
    assign preempt = 1'b0;
`endif

    assign idx_inc    = note_idx + 2'd1;
    assign start_note = melody(top_id, 2'd0);
    assign cont_note  = melody(active_id, idx_inc);

    always_comb begin
        state_nxt    = state;
        pending_nxt  = pending;
        note_idx_nxt = note_idx;
        tick_cnt_nxt = tick_cnt;
        enable_nxt   = enable_out;
        tone_nxt     = tone;
        busy_nxt     = busy;
        id_nxt       = active_id;
        done_nxt     = 1'b0;
        start        = 1'b0;
        next_note    = 1'b0;

        case (state)
            IDLE: start = top_vld;
            PLAY: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (tick) begin
                    if (tick_cnt + 8'd1 == NOTE_T) begin
                        tick_cnt_nxt = '0;
                        if (note_idx == 2'd3) begin
                            state_nxt  = IDLE;
                            enable_nxt = 1'b0;
                            tone_nxt   = '0;
                            busy_nxt   = 1'b0;
                            done_nxt   = 1'b1;
                        end else if (GAP_T != 8'd0) begin
                            state_nxt  = GAP;
                            enable_nxt = 1'b0;
                            tone_nxt   = REST;
                        end else begin
                            next_note = 1'b1;
                        end
                    end else begin
                        tick_cnt_nxt = tick_cnt + 8'd1;
                    end
                end
            end
            GAP: begin
                if (preempt) begin
                    start = 1'b1;
                end else if (tick) begin
                    if (tick_cnt + 8'd1 == GAP_T) next_note = 1'b1;
                    else                          tick_cnt_nxt = tick_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (next_note) begin
            state_nxt    = PLAY;
            note_idx_nxt = idx_inc;
            tick_cnt_nxt = '0;
            enable_nxt   = (cont_note != REST);
            tone_nxt     = cont_note;
        end

        if (start) begin
            state_nxt    = PLAY;
            id_nxt       = top_id;
            pending_nxt  = pending & ~(4'b0001 << top_id);
            note_idx_nxt = '0;
            tick_cnt_nxt = '0;
            busy_nxt     = 1'b1;
            enable_nxt   = (start_note != REST);
            tone_nxt     = start_note;
        end

        // A new request for the id just dequeued re-arms its bit for a replay.
        pending_nxt = pending_nxt | req;

        if (!enableSound) begin
            state_nxt    = IDLE;
            pending_nxt  = '0;
            note_idx_nxt = '0;
            tick_cnt_nxt = '0;
            enable_nxt   = 1'b0;
            tone_nxt     = '0;
            busy_nxt     = 1'b0;
            id_nxt       = '0;
            done_nxt     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state      <= IDLE;
            pending    <= '0;
            note_idx   <= '0;
            tick_cnt   <= '0;
            enable_out <= 1'b0;
            tone       <= '0;
            busy       <= 1'b0;
            active_id  <= '0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pending    <= pending_nxt;
            note_idx   <= note_idx_nxt;
            tick_cnt   <= tick_cnt_nxt;
            enable_out <= enable_nxt;
            tone       <= tone_nxt;
            busy       <= busy_nxt;
            active_id  <= id_nxt;
            done       <= done_nxt;
        end
    end

endmodule
